// File: rtl/fixed_prior_stream_mux.sv
// Packet-level N:1 stream multiplexer with fixed priority (lowest valid index wins).
// A grant is latched on the first beat of a packet and held until the beat carrying
// s_last is accepted; the mux then spends one idle cycle before arbitrating again.
// Optional feature macro FPSM_OUT_REG_EN: when defined, a 2-entry skid register sits
// on m_valid/m_data/m_last, so every m_* output and s_ready comes from flops.
module fixed_prior_stream_mux #(
    parameter  int NUM = 16,
    parameter  int DW  = 32,
    localparam int IW  = $clog2(NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM-1:0]    s_valid,
    output logic [NUM-1:0]    s_ready,
    input  logic [NUM*DW-1:0] s_data,
    input  logic [NUM-1:0]    s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic [NUM-1:0]    m_grant,
    output logic [IW-1:0]     m_idx,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    logic [NUM-1:0]  r_grant;
    logic [IW-1:0]   r_idx;

    logic [NUM-1:0]  w_req_gnt;
    logic [IW-1:0]   w_req_idx;
    logic [DW-1:0]   w_data_arr [NUM];
    logic [DW-1:0]   w_sel_data;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic            w_in_fire;

    // Lowest set request bit as a one-hot grant and as a binary index
    always_comb begin
        w_req_gnt = s_valid & ~(s_valid - NUM'(1));
        w_req_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (s_valid[i]) begin
                w_req_idx = IW'(i);
            end
        end
    end

    // Route the locked input's beat; nothing is selected while idle
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            w_data_arr[i] = s_data[i*DW +: DW];
        end
        w_sel_valid = (r_state == ST_LOCK) && s_valid[r_idx];
        w_sel_data  = w_data_arr[r_idx];
        w_sel_last  = s_last[r_idx];
    end

    // Arbitration FSM: latch the winner in IDLE, release after the last beat is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_valid) begin
                        r_state <= ST_LOCK;
                        r_grant <= w_req_gnt;
                        r_idx   <= w_req_idx;
                    end
                end
                ST_LOCK: begin
                    if (w_in_fire && w_sel_last) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign m_grant = r_grant;
    assign m_idx   = r_idx;
    assign busy    = (r_state == ST_LOCK);

`ifdef FPSM_OUT_REG_EN
    logic            r_o_vld;
    logic [DW-1:0]   r_o_data;
    logic            r_o_last;
    logic            r_k_vld;
    logic [DW-1:0]   r_k_data;
    logic            r_k_last;

    // Input side may push whenever the skid entry is free; ready depends only on flops
    assign w_in_fire = w_sel_valid && !r_k_vld;
    assign s_ready   = r_grant & {NUM{~r_k_vld}};

    // Skid pair: output entry drains first, skid entry catches a beat during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_vld  <= 1'b0;
            r_o_data <= '0;
            r_o_last <= 1'b0;
            r_k_vld  <= 1'b0;
            r_k_data <= '0;
            r_k_last <= 1'b0;
        end else if (!r_o_vld || m_ready) begin
            if (r_k_vld) begin
                r_o_vld  <= 1'b1;
                r_o_data <= r_k_data;
                r_o_last <= r_k_last;
                r_k_vld  <= 1'b0;
            end else if (w_in_fire) begin
                r_o_vld  <= 1'b1;
                r_o_data <= w_sel_data;
                r_o_last <= w_sel_last;
            end else begin
                r_o_vld  <= 1'b0;
                r_o_data <= '0;
                r_o_last <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_k_vld  <= 1'b1;
            r_k_data <= w_sel_data;
            r_k_last <= w_sel_last;
        end
    end

    assign m_valid = r_o_vld;
    assign m_data  = r_o_data;
    assign m_last  = r_o_last;
`else
    // Pass-through: downstream ready flows straight back to the locked source
    assign w_in_fire = w_sel_valid && m_ready;
    assign s_ready   = r_grant & {NUM{m_ready}};
    assign m_valid   = w_sel_valid;
    assign m_data    = (r_state == ST_LOCK) ? w_sel_data : '0;
    assign m_last    = (r_state == ST_LOCK) ? w_sel_last : 1'b0;
`endif

endmodule

// File: tb/tb_fixed_prior_stream_mux.sv
// Directed scoreboard bench for fixed_prior_stream_mux (both build options).
module tb_fixed_prior_stream_mux;

    localparam int NUM = 16;
    localparam int DW  = 32;
    localparam int IW  = 4;
`ifdef FPSM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic [NUM-1:0]    s_valid = '0;
    logic [NUM-1:0]    s_ready;
    logic [NUM*DW-1:0] s_data  = '0;
    logic [NUM-1:0]    s_last  = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [NUM-1:0]    m_grant;
    logic [IW-1:0]     m_idx;
    logic              busy;

    fixed_prior_stream_mux #(.NUM(NUM), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_grant (m_grant),
        .m_idx   (m_idx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [DW:0]   srcq [NUM][$];
    logic [DW:0]   sb [$];
    int            hs_q [$];
    logic [NUM-1:0] fired = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int idx, input int pkt, input int nb);
        logic [DW-1:0] d;
        logic [DW:0]   e;
        for (int b = 0; b < nb; b++) begin
            d = {idx[7:0], pkt[7:0], b[15:0]};
            e = {(b == nb - 1), d};
            srcq[idx].push_back(e);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 200 && sb.size() != 0; k++) step();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source models: present the head of each per-input queue, pop on handshake
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                s_valid[i]            = 1'b1;
                s_last[i]             = srcq[i][0][DW];
                s_data[i*DW +: DW]    = srcq[i][0][DW-1:0];
            end else begin
                s_valid[i]            = 1'b0;
                s_last[i]             = 1'b0;
                s_data[i*DW +: DW]    = '0;
            end
        end
    end

    // Output monitor: scoreboard pop on each accepted beat, hold check on stalls
    initial forever begin
        logic [DW:0] ev;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
            fired      = '0;
        end else begin
            fired = s_valid & s_ready;
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                hs_q.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    ev = sb.pop_front();
                    chk("beat", 64'({m_last, m_data}), 64'(ev));
                end
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int off1 [6] = '{0, 1, 2, 4, 5, 6};
        logic saw0;
        logic [NUM-1:0] a, b;

        // Reset state
        rst = 1'b1;
        m_ready = 1'b0;
        step();
        step();
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_grant",   64'(m_grant), 64'd0);
        chk("rst_idx",     64'(m_idx),   64'd0);
        chk("rst_sready",  64'(s_ready), 64'd0);
        chk("rst_mvalid",  64'(m_valid), 64'd0);
        chk("rst_mdata",   64'(m_data),  64'd0);
        chk("rst_mlast",   64'(m_last),  64'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        step();

        // 1) inputs 2 and 4 request together; 2 wins, one idle cycle, then 4
        hs_q.delete();
        push_pkt(2, 1, 3);
        push_pkt(4, 1, 3);
        t0 = cyc;
        step();
        step();
        chk("t1_idx2",   64'(m_idx),   64'd2);
        chk("t1_grant2", 64'(m_grant), 64'h0004);
        chk("t1_busy",   64'(busy),    64'd1);
        step();
        step();
        step();
        chk("t1_gap_busy",  64'(busy),    64'd0);
        chk("t1_gap_grant", 64'(m_grant), 64'd0);
        step();
        chk("t1_idx4",   64'(m_idx),   64'd4);
        chk("t1_grant4", 64'(m_grant), 64'h0010);
        wait_drain("t1_drain");
        chk("t1_nbeats", 64'(hs_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < hs_q.size(); k++)
            chk("t1_beat_cycle", 64'(hs_q[k]), 64'(t0 + 1 + LAT + off1[k]));

        // 2) input 0 requests mid-packet of input 5 and must wait
        step();
        hs_q.delete();
        push_pkt(5, 2, 4);
        for (int k = 0; k < 50 && hs_q.size() < 1; k++) step();
        chk("t2_first_beat", 64'(hs_q.size() >= 1), 64'd1);
        push_pkt(0, 2, 2);
        saw0 = 1'b0;
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            step();
            if (busy && m_idx == 5) chk("t2_sready0", 64'(s_ready[0]), 64'd0);
            if (busy && m_idx == 0) saw0 = 1'b1;
        end
        chk("t2_drain", 64'(sb.size()), 64'd0);
        chk("t2_grant0_seen", 64'(saw0), 64'd1);

        // 3) back-pressure 1,0,0,1 during a 4-beat packet from input 6
        step();
        hs_q.delete();
        push_pkt(6, 3, 4);
        for (int k = 0; k < 20 && !m_valid; k++) step();
        chk("t3_valid", 64'(m_valid), 64'd1);
        step();
        a = s_ready;
        m_ready = 1'b0;
        #1;
        b = s_ready;
`ifdef FPSM_OUT_REG_EN
        chk("t3_sready_registered", 64'(b), 64'(a));
`else
        chk("t3_sready_follow_hi", 64'(a), 64'h0040);
        chk("t3_sready_follow_lo", 64'(b), 64'd0);
`endif
        step();
        m_ready = 1'b0;
        step();
        m_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_nbeats", 64'(hs_q.size()), 64'd4);

        // 4) continuous single-beat packets from input 1
        step();
        hs_q.delete();
        for (int p = 0; p < 4; p++) push_pkt(1, 4 + p, 1);
        t0 = cyc;
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            chk("t4_busy", 64'(busy), 64'(k % 2 == 0));
            step();
        end
        wait_drain("t4_drain");
        chk("t4_nbeats", 64'(hs_q.size()), 64'd4);
        if (hs_q.size() >= 1) chk("t4_first", 64'(hs_q[0]), 64'(t0 + 1 + LAT));
        for (int k = 1; k < hs_q.size(); k++)
            chk("t4_spacing", 64'(hs_q[k] - hs_q[k-1]), 64'd2);

        // 5) reset in the middle of a 5-beat packet, then a fresh packet
        step();
        hs_q.delete();
        push_pkt(3, 5, 5);
        for (int k = 0; k < 50 && hs_q.size() < 2; k++) step();
        chk("t5_two_beats", 64'(hs_q.size() >= 2), 64'd1);
        rst = 1'b1;
        srcq[3].delete();
        sb.delete();
        step();
        chk("t5_busy",   64'(busy),    64'd0);
        chk("t5_grant",  64'(m_grant), 64'd0);
        chk("t5_sready", 64'(s_ready), 64'd0);
        chk("t5_mvalid", 64'(m_valid), 64'd0);
        chk("t5_idx",    64'(m_idx),   64'd0);
        rst = 1'b0;
        step();
        hs_q.delete();
        push_pkt(7, 6, 2);
        step();
        step();
        chk("t5_idx7",   64'(m_idx),   64'd7);
        chk("t5_grant7", 64'(m_grant), 64'h0080);
        wait_drain("t5_drain");
        chk("t5_nbeats", 64'(hs_q.size()), 64'd2);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
